// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory responder: access widths, FSM states
// and the latency counter width.
package dm_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    WIDTH_WORD = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_BYTE = 2'b10,
    WIDTH_ILL  = 2'b11
  } width_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane datapath: merges store data into an existing word and extracts
// a sign- or zero-extended byte/half/word for loads.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  width,
  input  logic [1:0]  lane,
  input  logic        sign,
  output logic [31:0] merged,
  output logic [31:0] ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    merged = word;
    ext    = word;
    case (width)
      WIDTH_WORD: merged = wdata;
      WIDTH_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
        ext = {{16{sign & half_v[15]}}, half_v};
      end
      WIDTH_BYTE: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        ext = {{24{sign & byte_v[7]}}, byte_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder with valid/ready request, LATENCY-cycle
// response and lane-aware stores/loads. Define DM_WRITE_LOG_EN to log commits.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_width,
  input  logic        req_sign,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int               IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0]      ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d, sign_q, sign_d, err_q, err_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]        width_q, width_d;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              fire, exec, cur_we, cur_sign, cur_err;
  logic [31:0]       cur_addr, cur_wdata, old_word, new_word, ext_data;
  logic [1:0]        cur_width;
  logic [IDX_W-1:0]  cur_idx;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign fire       = req_valid && req_ready;

  // With LATENCY 1 the access executes on the acceptance edge, straight from the ports.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we = req_we;  cur_addr = req_addr;  cur_wdata = req_wdata;
      cur_width = req_width;  cur_sign = req_sign;
    end else begin
      cur_we = we_q;  cur_addr = addr_q;  cur_wdata = wdata_q;
      cur_width = width_q;  cur_sign = sign_q;
    end
  end

  assign cur_idx  = cur_addr[2 +: IDX_W];
  assign old_word = mem_q[cur_idx];
  assign cur_err  = (cur_width == WIDTH_ILL) ||
                    ((cur_width == WIDTH_HALF) && cur_addr[0]) ||
                    ((cur_width == WIDTH_WORD) && (cur_addr[1:0] != 2'b00)) ||
                    (cur_addr >= ADDR_LIMIT);

  dm_lane_unit u_lane (
    .word   (old_word),
    .wdata  (cur_wdata),
    .width  (cur_width),
    .lane   (cur_addr[1:0]),
    .sign   (cur_sign),
    .merged (new_word),
    .ext    (ext_data)
  );

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;
    we_d = we_q;  addr_d = addr_q;  wdata_d = wdata_q;  width_d = width_q;  sign_d = sign_q;
    rdata_d = rdata_q;  err_d = err_q;
    exec = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          we_d = req_we;  addr_d = req_addr;  wdata_d = req_wdata;
          width_d = req_width;  sign_d = req_sign;
          if (LATENCY == 1) begin
            exec    = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          exec    = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (exec) begin
      err_d   = cur_err;
      rdata_d = (cur_err || cur_we) ? 32'h0 : ext_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;  cnt_q <= '0;
      we_q <= 1'b0;  addr_q <= '0;  wdata_q <= '0;  width_q <= '0;  sign_q <= 1'b0;
      rdata_q <= '0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;
      we_q <= we_d;  addr_q <= addr_d;  wdata_q <= wdata_d;  width_q <= width_d;  sign_q <= sign_d;
      rdata_q <= rdata_d;  err_q <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (exec && cur_we && !cur_err) begin
      mem_q[cur_idx] <= new_word;
    end
  end

`ifdef DM_WRITE_LOG_EN
  logic [31:0] pc_q, pc_d, cur_pc;

  assign pc_d   = fire ? req_pc : pc_q;
  assign cur_pc = (state_q == ST_IDLE) ? req_pc : pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset && exec && cur_we && !cur_err)
      $display("%d@%h: *%h <= %h", $time, cur_pc, {cur_addr[31:2], 2'b00}, new_word);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a LATENCY=2 instance for functional,
// error and reset cases, plus a LATENCY=1 instance for back-to-back traffic.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_we, req_sign, resp_valid, resp_err;
  logic [31:0] req_addr, req_wdata, req_pc, resp_rdata;
  logic [1:0]  req_width;

  logic        rst1_n, valid1, ready1, we1, sign1, resp_valid1, resp_err1;
  logic [31:0] addr1, wdata1, resp_rdata1;
  logic [1:0]  width1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_WORDS(3072), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
    .req_sign(req_sign), .req_pc(req_pc), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.DEPTH_WORDS(3072), .LATENCY(1)) dut1 (
    .clk(clk), .reset(rst1_n), .req_valid(valid1), .req_ready(ready1),
    .req_we(we1), .req_addr(addr1), .req_wdata(wdata1), .req_width(width1),
    .req_sign(sign1), .req_pc(32'h0000_2000), .resp_valid(resp_valid1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One transaction on the LATENCY=2 instance; inputs are scrambled after acceptance.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] w, input logic s,
                      output logic [31:0] rd, output logic er, output int lat, output logic rdy1);
    @(negedge clk);
    req_valid = 1'b1;  req_we = we;  req_addr = a;  req_wdata = d;  req_width = w;  req_sign = s;
    req_pc = 32'h0000_1000;
    @(negedge clk);
    req_valid = 1'b0;  req_we = 1'b1;  req_addr = 32'h10;  req_wdata = 32'hFFFF_FFFF;
    req_width = 2'b00;  req_sign = 1'b1;
    rdy1 = req_ready;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  w;
    logic        s;
    logic [31:0] exp;
  } vec_t;

  initial begin
    logic [31:0] rd;
    logic        er, rdy1, will;
    int          lat, nxt, got, prev_acc, n_acc;
    vec_t        v1 [5];
    logic [31:0] expq [$];
    int          accq [$];

    reset = 1'b0;  rst1_n = 1'b0;
    req_valid = 1'b0;  req_we = 1'b0;  req_addr = '0;  req_wdata = '0;
    req_width = '0;  req_sign = 1'b0;  req_pc = '0;
    valid1 = 1'b0;  we1 = 1'b0;  addr1 = '0;  wdata1 = '0;  width1 = '0;  sign1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    reset = 1'b1;  rst1_n = 1'b1;

    xact(1'b1, 32'h10, 32'h1234_5678, 2'b00, 1'b0, rd, er, lat, rdy1);
    chk("sw_ready_drop", {31'b0, rdy1}, 32'd0);
    chk("sw_latency", 32'(lat), 32'd2);
    chk("sw_err", {31'b0, er}, 32'd0);
    chk("sw_rdata", rd, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, er, lat, rdy1);
    chk("lw_10", rd, 32'h1234_5678);
    chk("lw_latency", 32'(lat), 32'd2);

    xact(1'b1, 32'h11, 32'h0000_00AB, 2'b10, 1'b0, rd, er, lat, rdy1);
    xact(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, er, lat, rdy1);
    chk("lw_after_sb", rd, 32'h1234_AB78);
    xact(1'b0, 32'h11, 32'h0, 2'b10, 1'b1, rd, er, lat, rdy1);
    chk("lb_signed", rd, 32'hFFFF_FFAB);
    xact(1'b0, 32'h11, 32'h0, 2'b10, 1'b0, rd, er, lat, rdy1);
    chk("lb_unsigned", rd, 32'h0000_00AB);

    xact(1'b1, 32'h12, 32'h0000_8001, 2'b01, 1'b0, rd, er, lat, rdy1);
    xact(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, rd, er, lat, rdy1);
    chk("lh_signed", rd, 32'hFFFF_8001);
    xact(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, rd, er, lat, rdy1);
    chk("lh_unsigned", rd, 32'h0000_8001);
    xact(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, er, lat, rdy1);
    chk("lw_after_sh", rd, 32'h8001_AB78);

    xact(1'b1, 32'h13, 32'hFFFF_FFFF, 2'b00, 1'b0, rd, er, lat, rdy1);
    chk("err_sw_mis_err", {31'b0, er}, 32'd1);
    chk("err_sw_mis_rdata", rd, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, er, lat, rdy1);
    chk("err_sw_mis_mem", rd, 32'h8001_AB78);

    xact(1'b0, 32'h21, 32'h0, 2'b01, 1'b1, rd, er, lat, rdy1);
    chk("err_lh_mis_err", {31'b0, er}, 32'd1);
    chk("err_lh_mis_rdata", rd, 32'h0);

    xact(1'b1, 32'h10, 32'hFFFF_FFFF, 2'b11, 1'b0, rd, er, lat, rdy1);
    chk("err_w11_err", {31'b0, er}, 32'd1);
    chk("err_w11_rdata", rd, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, er, lat, rdy1);
    chk("err_w11_mem", rd, 32'h8001_AB78);
    chk("ok_after_err", {31'b0, er}, 32'd0);

    xact(1'b1, 32'h2FFC, 32'hCAFE_F00D, 2'b00, 1'b0, rd, er, lat, rdy1);
    xact(1'b1, 32'h3000, 32'hFFFF_FFFF, 2'b00, 1'b0, rd, er, lat, rdy1);
    chk("err_range_err", {31'b0, er}, 32'd1);
    chk("err_range_rdata", rd, 32'h0);
    xact(1'b0, 32'h3000, 32'h0, 2'b10, 1'b0, rd, er, lat, rdy1);
    chk("err_range_load_err", {31'b0, er}, 32'd1);
    xact(1'b0, 32'h2FFC, 32'h0, 2'b00, 1'b0, rd, er, lat, rdy1);
    chk("last_word", rd, 32'hCAFE_F00D);
    chk("last_word_err", {31'b0, er}, 32'd0);

    @(negedge clk);
    req_valid = 1'b1;  req_we = 1'b1;  req_addr = 32'h20;  req_wdata = 32'hDEAD_BEEF;
    req_width = 2'b00;  req_sign = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wait_ready_low", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    xact(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, rd, er, lat, rdy1);
    chk("midrst_lw_20", rd, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, er, lat, rdy1);
    chk("midrst_mem_clear", rd, 32'h0);

    v1[0] = '{1'b1, 32'h40, 32'h1111_1111, 2'b00, 1'b0, 32'h0000_0000};
    v1[1] = '{1'b0, 32'h40, 32'h0,         2'b00, 1'b0, 32'h1111_1111};
    v1[2] = '{1'b1, 32'h41, 32'h0000_0080, 2'b10, 1'b0, 32'h0000_0000};
    v1[3] = '{1'b0, 32'h41, 32'h0,         2'b10, 1'b1, 32'hFFFF_FF80};
    v1[4] = '{1'b0, 32'h40, 32'h0,         2'b00, 1'b0, 32'h1111_8011};
    nxt = 0;  got = 0;  prev_acc = -10;  n_acc = 0;
    @(negedge clk);
    valid1 = 1'b1;  we1 = v1[0].we;  addr1 = v1[0].a;  wdata1 = v1[0].d;
    width1 = v1[0].w;  sign1 = v1[0].s;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (resp_valid1) begin
        chk("l1_resp_expected", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          chk("l1_rdata", resp_rdata1, expq.pop_front());
          chk("l1_latency", 32'(cyc - accq.pop_front()), 32'd1);
          chk("l1_err", {31'b0, resp_err1}, 32'd0);
        end
        got++;
      end
      will = valid1 && ready1;
      if (will) begin
        expq.push_back(v1[nxt].exp);
        accq.push_back(cyc);
        if (n_acc > 0) chk("l1_accept_gap", 32'(cyc - prev_acc), 32'd2);
        prev_acc = cyc;
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (will) begin
        nxt++;
        if (nxt < 5) begin
          we1 = v1[nxt].we;  addr1 = v1[nxt].a;  wdata1 = v1[nxt].d;
          width1 = v1[nxt].w;  sign1 = v1[nxt].s;
        end else begin
          valid1 = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("l1_responses", 32'(got), 32'd5);
    chk("l1_accepts", 32'(n_acc), 32'd5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("l1_no_extra_resp", {31'b0, resp_valid1}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
